// File: rtl/cache_access_ctrl.sv
// Shares a 4-line LRU cache between IF and MEM requesters: arbitrates, looks up, refills misses
// from backing memory, and does write-through/write-allocate stores. Optional CACHE_CTRL_STATS_EN adds hit/miss counters.
module cache_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_mem_ack,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic [TAG_W-1:0]  o_c_tag,
  output logic [DATA_W-1:0] o_c_wdata,
  output logic              o_c_rd_n,
  output logic              o_c_wr_n,
  input  logic              i_c_miss,
  input  logic [DATA_W-1:0] i_c_rdata,
  output logic              o_bm_req,
  output logic              o_bm_we,
  output logic [ADDR_W-1:0] o_bm_addr,
  output logic [DATA_W-1:0] o_bm_wdata,
  input  logic              i_bm_ack,
  input  logic [DATA_W-1:0] i_bm_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RESP, S_FETCH, S_FILL, S_WRMEM, S_WRUPD
  } state_t;

  state_t            r_state, w_next;
  logic              r_gnt_mem;   // current owner: 1=MEM, 0=IF
  logic              r_last_mem;  // last granted requester, for conflict fairness
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fill;
  logic              r_hit;

  logic              w_grant, w_pick_mem, w_resp;
  logic [DATA_W-1:0] w_rdata;

  // On a conflict the requester that did not win last time is served.
  assign w_grant    = i_if_req | i_mem_req;
  assign w_pick_mem = i_mem_req & (~i_if_req | ~r_last_mem);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_gnt_mem  <= 1'b0;
      r_last_mem <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_fill     <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_grant) begin
        r_gnt_mem  <= w_pick_mem;
        r_last_mem <= w_pick_mem;
        r_addr     <= w_pick_mem ? i_mem_addr : i_if_addr;
        r_we       <= w_pick_mem & i_mem_we;
        r_wdata    <= w_pick_mem ? i_mem_wdata : '0;
      end
      if (r_state == S_LOOKUP) r_hit <= ~i_c_miss;
      if (r_state == S_FETCH && i_bm_ack) r_fill <= i_bm_rdata;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = (w_pick_mem && i_mem_we) ? S_WRMEM : S_LOOKUP;
      S_LOOKUP: w_next = i_c_miss ? S_FETCH : S_RESP;
      S_FETCH:  if (i_bm_ack) w_next = S_FILL;
      S_FILL:   w_next = S_RESP;
      S_WRMEM:  if (i_bm_ack) w_next = S_WRUPD;
      S_WRUPD:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Hit data arrives from the cache read buffer the cycle after the lookup strobe.
  assign w_rdata = r_hit ? i_c_rdata : r_fill;
  assign w_resp  = (r_state == S_RESP);

  always_comb begin
    o_c_rd_n    = (r_state != S_LOOKUP);
    o_c_wr_n    = ~((r_state == S_FILL) | (r_state == S_WRUPD));
    o_c_tag     = r_addr[TAG_W+1:2];
    o_c_wdata   = '0;
    if (r_state == S_FILL)  o_c_wdata = r_fill;
    if (r_state == S_WRUPD) o_c_wdata = r_wdata;
    o_bm_req    = (r_state == S_FETCH) | (r_state == S_WRMEM);
    o_bm_we     = (r_state == S_WRMEM);
    o_bm_addr   = r_addr;
    o_bm_wdata  = r_wdata;
    o_if_ack    = w_resp & ~r_gnt_mem;
    o_mem_ack   = w_resp & r_gnt_mem;
    o_if_rdata  = o_if_ack ? w_rdata : '0;
    o_mem_rdata = (o_mem_ack & ~r_we) ? w_rdata : '0;
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (!i_c_miss && r_hit_cnt != 16'hFFFF)  r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (i_c_miss && r_miss_cnt != 16'hFFFF)  r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Bench for cache_access_ctrl: cache and backing-memory stubs, plus a word-level reference model
// of what each requester should read back.
module tb_cache_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  c_tag;
  logic [31:0] c_wdata;
  logic        c_rd_n, c_wr_n;
  logic        c_miss;
  logic [31:0] c_rdata = '0;
  logic        bm_req, bm_we;
  logic [31:0] bm_addr, bm_wdata;
  logic        bm_ack = 1'b0;
  logic [31:0] bm_rdata = '0;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_access_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_ack(mem_ack), .o_mem_rdata(mem_rdata),
    .o_c_tag(c_tag), .o_c_wdata(c_wdata), .o_c_rd_n(c_rd_n), .o_c_wr_n(c_wr_n),
    .i_c_miss(c_miss), .i_c_rdata(c_rdata),
    .o_bm_req(bm_req), .o_bm_we(bm_we), .o_bm_addr(bm_addr), .o_bm_wdata(bm_wdata),
    .i_bm_ack(bm_ack), .i_bm_rdata(bm_rdata)
`ifdef CACHE_CTRL_STATS_EN
    , .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int idx);
    return (idx == 2) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(idx) * 32'h11;
  endfunction

  // Cache stub: one line per tag (4 tags, 4 lines, so nothing is ever evicted).
  bit [3:0]    cvalid = '0;
  logic [31:0] cdata [4];
  bit          flush_req = 1'b0;
  assign c_miss = ~cvalid[c_tag];
  always @(posedge clk) begin
    if (flush_req) cvalid <= '0;
    if (!c_wr_n) begin cdata[c_tag] <= c_wdata; cvalid[c_tag] <= 1'b1; end
    if (!c_rd_n) c_rdata <= cdata[c_tag];
  end

  // Backing memory stub: acks after bm_dly waiting cycles with bm_req held.
  int          bm_dly = 2;
  int          bcnt = 0;
  logic [31:0] bmem [256];
  bit          bwr  [256];
  always @(negedge clk) begin
    int idx;
    if (bm_ack) begin
      bm_ack = 1'b0; bcnt = 0;
    end else if (bm_req) begin
      if (bcnt >= bm_dly) begin
        idx = int'(bm_addr[9:2]);
        bm_ack = 1'b1;
        if (bm_we) begin bmem[idx] = bm_wdata; bwr[idx] = 1'b1; end
        else bm_rdata = bwr[idx] ? bmem[idx] : init_val(idx);
      end else bcnt++;
    end else bcnt = 0;
  end

  // Protocol monitors.
  logic        prev_bm_req = 1'b0;
  logic [31:0] prev_bm_addr = '0;
  always @(negedge clk) begin
    chk("strobe_excl", {31'b0, c_rd_n | c_wr_n}, 32'd1);
    chk("ack_overlap", {31'b0, if_ack & mem_ack}, 32'd0);
    if (bm_req && prev_bm_req) chk("bm_addr_stable", bm_addr, prev_bm_addr);
    prev_bm_req  = bm_req;
    prev_bm_addr = bm_addr;
  end

  // Reference model: memory words, per-tag cache contents, arbitration history, stats.
  logic [31:0] rm [256];
  bit          rm_wr [256];
  bit   [3:0]  rc_valid = '0;
  logic [31:0] rc_data [4];
  bit          ref_last_if = 1'b1;
  int          ref_hit = 0, ref_miss = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a, output bit miss);
    int t = int'(a[3:2]);
    int i = int'(a[9:2]);
    miss = ~rc_valid[t];
    if (miss) begin
      rc_data[t]  = rm_wr[i] ? rm[i] : init_val(i);
      rc_valid[t] = 1'b1;
      ref_miss++;
    end else ref_hit++;
    return rc_data[t];
  endfunction

  bit          saw_bm, saw_cw, wrong_ack;
  logic        s_bm_we;
  logic [31:0] s_bm_wd, s_bm_addr, s_cw_d;
  logic [1:0]  s_cw_tag;

  task automatic do_txn(input bit is_if, input bit we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp, rd;
    bit          exp_miss, done;
    int          n;
    exp = '0; exp_miss = 1'b0; rd = '0;
    if (we) begin
      rm[int'(a[9:2])] = wd; rm_wr[int'(a[9:2])] = 1'b1;
      rc_data[int'(a[3:2])] = wd; rc_valid[int'(a[3:2])] = 1'b1;
    end else exp = ref_read(a, exp_miss);
    ref_last_if = is_if;
    @(negedge clk);
    if (is_if) begin if_req = 1'b1; if_addr = a; end
    else begin mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; end
    saw_bm = 0; saw_cw = 0; wrong_ack = 0; done = 0; n = 0;
    while (!done && n < 300) begin
      @(negedge clk); n++;
      if (n == 1) begin  // latched at grant: later input changes must be ignored
        if (is_if) if_addr = $urandom;
        else begin mem_addr = $urandom; mem_wdata = $urandom; mem_we = ~we; end
      end
      if (bm_req) begin saw_bm = 1; s_bm_we = bm_we; s_bm_wd = bm_wdata; s_bm_addr = bm_addr; end
      if (!c_wr_n) begin saw_cw = 1; s_cw_tag = c_tag; s_cw_d = c_wdata; end
      if (is_if ? mem_ack : if_ack) wrong_ack = 1;
      if (is_if ? if_ack : mem_ack) begin done = 1; rd = is_if ? if_rdata : mem_rdata; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("ack_timeout", {31'b0, done}, 32'd1);
    chk("wrong_ack", {31'b0, wrong_ack}, 32'd0);
    if (we) begin
      chk("wr_bm_used", {31'b0, saw_bm}, 32'd1);
      chk("wr_bm_we", {31'b0, s_bm_we}, 32'd1);
      chk("wr_bm_wdata", s_bm_wd, wd);
      chk("wr_bm_addr", s_bm_addr, a);
      chk("wr_cache_upd", {31'b0, saw_cw}, 32'd1);
      chk("wr_cache_tag", {30'b0, s_cw_tag}, {30'b0, a[3:2]});
      chk("wr_cache_data", s_cw_d, wd);
    end else begin
      chk("rd_data", rd, exp);
      chk("rd_bm_used", {31'b0, saw_bm}, {31'b0, exp_miss});
      if (exp_miss) begin
        chk("fill_tag", {30'b0, s_cw_tag}, {30'b0, a[3:2]});
        chk("fill_data", s_cw_d, exp);
        chk("fetch_we", {31'b0, s_bm_we}, 32'd0);
        chk("fetch_addr", s_bm_addr, a);
      end else begin
        // grant cycle, lookup cycle, ack cycle
        chk("hit_latency", n, 32'd2);
        chk("hit_no_cwr", {31'b0, saw_cw}, 32'd0);
      end
    end
  endtask

  task automatic do_conflict(input logic [31:0] a_if, input logic [31:0] a_mem);
    logic [31:0] e_if, e_mem;
    bit          m_if, m_mem, mem_first, got_if, got_mem, first_mem, first_set;
    int          n;
    mem_first = ref_last_if;
    if (mem_first) begin e_mem = ref_read(a_mem, m_mem); e_if = ref_read(a_if, m_if); end
    else begin e_if = ref_read(a_if, m_if); e_mem = ref_read(a_mem, m_mem); end
    ref_last_if = mem_first;
    @(negedge clk);
    if_req = 1'b1; if_addr = a_if;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = a_mem;
    got_if = 0; got_mem = 0; first_set = 0; first_mem = 0; n = 0;
    while (!(got_if && got_mem) && n < 300) begin
      @(negedge clk); n++;
      if (if_ack) begin
        chk("cf_if_data", if_rdata, e_if);
        if (!first_set) begin first_set = 1; first_mem = 0; end
        got_if = 1; if_req = 1'b0;
      end
      if (mem_ack) begin
        chk("cf_mem_data", mem_rdata, e_mem);
        if (!first_set) begin first_set = 1; first_mem = 1; end
        got_mem = 1; mem_req = 1'b0;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("cf_both_acked", {30'b0, got_if, got_mem}, 32'd3);
    chk("cf_first_grant_mem", {31'b0, first_mem}, {31'b0, mem_first});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_last_if = 1'b1; ref_hit = 0; ref_miss = 0;
  endtask

  initial begin
    bit found;
    int op;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {26'b0, if_ack, mem_ack, c_rd_n, c_wr_n, bm_req, bm_we}, 32'b001100);
    chk("reset_data", bm_addr | bm_wdata | c_wdata | if_rdata | mem_rdata | {30'b0, c_tag}, 32'd0);
    rst = 1'b0;

    bm_dly = 2;
    do_txn(1, 0, 32'h8, 32'h0);          // miss, refill tag 2 with 0xDEADBEEF
    do_txn(1, 0, 32'h8, 32'h0);          // hit, no backing-memory traffic
    do_txn(0, 1, 32'h4, 32'h1234);       // write-through + allocate
    do_txn(0, 0, 32'h4, 32'h0);          // hit on the written word
`ifdef CACHE_CTRL_STATS_EN
    chk("stats_hit_s123", {16'b0, hit_cnt}, 32'd2);
    chk("stats_miss_s123", {16'b0, miss_cnt}, 32'd1);
`endif

    pulse_reset();
    do_conflict(32'h8, 32'h4);
    do_conflict(32'h8, 32'h4);

    // Reset while a fetch is outstanding.
    bm_dly = 5;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hC;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bm_req) found = 1;
    end
    chk("rst_fetch_reached", {31'b0, found}, 32'd1);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_bm_req", {31'b0, bm_req}, 32'd0);
    chk("rst_mid_acks", {30'b0, if_ack, mem_ack}, 32'd0);
    rst = 1'b0;
    ref_last_if = 1'b1; ref_hit = 0; ref_miss = 0;
    @(negedge clk);
    chk("rst_mid_idle_ack", {30'b0, if_ack, mem_ack}, 32'd0);
    bm_dly = 1;
    do_txn(1, 0, 32'hC, 32'h0);

    // Randomized mix of reads, writes and cache flushes.
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      a  = {28'b0, 2'($urandom_range(0, 3)), 2'b00};
      bm_dly = $urandom_range(0, 4);
      if (op == 0) begin
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        rc_valid = '0;
      end else if (op <= 3) do_txn(0, 1, a, $urandom);
      else if (op <= 6)     do_txn(1, 0, a, 32'h0);
      else                  do_txn(0, 0, a, 32'h0);
    end
    do_conflict(32'h0, 32'hC);

`ifdef CACHE_CTRL_STATS_EN
    @(negedge clk);
    chk("stats_hit_final", {16'b0, hit_cnt}, 32'(ref_hit));
    chk("stats_miss_final", {16'b0, miss_cnt}, 32'(ref_miss));
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
